pll_cen_gen: RTL

- Multi-channel fractional clock-enable generator driven from one PLL output clock.
- Replaces fixed extra PLL outputs: derives NUM_CH clock-enable strobes at arbitrary NUM/DEN ratios of refclk.
- Gates all enables behind a lock-qualification sequencer fed by the PLL locked flag.
- Sits directly after the PLL instance and feeds core, video and audio logic.

---
 rtl/pll_cen_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: lock-qualified multi-channel fractional clock-enable generator.
// Define CEN_RUNTIME_CFG_EN to add runtime-writable per-channel ratio registers.
module pll_cen_gen #(
    parameter int                        NUM_CH      = 3,
    parameter int                        ACC_W       = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   CH_NUM      = {16'd1, 16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0]   CH_DEN      = {16'd2, 16'd8, 16'd1},
    parameter int                        LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              sync,
`ifdef CEN_RUNTIME_CFG_EN
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
`endif
    output logic [NUM_CH-1:0] cen,
    output logic              ready,
    output logic              locked
);
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_QUALIFY  = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam int         CW          = $clog2(LOCK_CYCLES + 1);

    logic                              sync1_q, sync2_q;
    logic [1:0]                        state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              qual_done, acc_en, acc_clr;
    logic [NUM_CH-1:0][ACC_W-1:0]      acc_q, acc_d, num_w, den_w;
    logic [NUM_CH-1:0][ACC_W:0]        sum_w;
    logic [NUM_CH-1:0]                 cen_q, cen_d, ovf_w, wr_w;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
            acc_q   <= '0;
            cen_q   <= '0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            cen_q   <= cen_d;
        end
    end

    // The locked sample that leaves UNLOCKED is the first of the LOCK_CYCLES qualifying samples.
    assign qual_done = int'(cnt_q) + 1 >= LOCK_CYCLES - 1;

    always_comb begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
        if (sync2_q) begin
            state_d = (state_q == ST_UNLOCKED) ? ST_QUALIFY :
                      (state_q == ST_RUN || (state_q == ST_QUALIFY && qual_done)) ? ST_RUN :
                      (state_q == ST_QUALIFY) ? ST_QUALIFY : ST_UNLOCKED;
            cnt_d   = (state_q == ST_QUALIFY && !qual_done) ? cnt_q + 1'b1 : '0;
        end
    end

    // The RUN entry edge already adds from the zeroed accumulator; sync only acts while in RUN.
    assign acc_en  = state_d == ST_RUN;
    assign acc_clr = sync && state_q == ST_RUN;

    always_comb begin
        sum_w = '0;
        ovf_w = '0;
        acc_d = '0;
        cen_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_w[i] = {1'b0, acc_q[i]} + {1'b0, num_w[i]};
            ovf_w[i] = sum_w[i] >= {1'b0, den_w[i]};
            acc_d[i] = (acc_en && !acc_clr && !wr_w[i]) ? sum_w[i][ACC_W-1:0] - (ovf_w[i] ? den_w[i] : '0) : '0;
            cen_d[i] = acc_en && !acc_clr && !wr_w[i] && ovf_w[i];
        end
    end

`ifdef CEN_RUNTIME_CFG_EN
    logic [NUM_CH-1:0][ACC_W-1:0] num_q, den_q;

    always_comb begin
        wr_w = '0;
        for (int i = 0; i < NUM_CH; i++) wr_w[i] = cfg_we && cfg_ch == 3'(i);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            num_q <= CH_NUM;
            den_q <= CH_DEN;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_w[i]) begin
                    num_q[i] <= cfg_num;
                    den_q[i] <= cfg_den;
                end
            end
        end
    end

    assign num_w = num_q;
    assign den_w = den_q;
`else
    assign wr_w  = '0;
    assign num_w = CH_NUM;
    assign den_w = CH_DEN;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
        a_ratio: assert property (@(posedge refclk) disable iff (rst) den_w[c] != '0 && num_w[c] <= den_w[c]);
    end

    assign cen    = cen_q;
    assign ready  = state_q == ST_RUN;
    assign locked = sync2_q;
endmodule
